fifo_ctrl_6x8: RTL
==================

// Module: fifo_ctrl_6x8
// PURPOSE
//   FIFO controller that drives memory6x8's read/write/pointer interface on behalf of a
//   push/pop client (switch ingress/egress logic). Owns wr/rd pointers with mod-DEPTH wrap
//   and the occupancy counter. Produces full/empty, almost-full/almost-empty for the adaptive
//   flow logic, plus sticky overflow/underflow errors. One controller per memory6x8 instance.
// PARAMETERS
//   MAIN_SIZE  6  pointer/occupancy width; matches memory6x8 wr_ptr/rd_ptr width
//   DATA_SIZE  8  data word width
//   DEPTH      6  entries used; pointers wrap DEPTH-1 -> 0 (non-power-of-two)
//   AF_THR     4  almost_full when occupancy >= AF_THR
//   AE_THR     1  almost_empty when occupancy <= AE_THR; AE_THR < AF_THR <= DEPTH required
// PORTS
//   clk           in   1          clock; all state updates on rising edge
//   reset         in   1          asynchronous, active-low reset
//   push          in   1          client write request
//   push_data     in   DATA_SIZE  word to write
//   pop           in   1          client read request
//   pop_data      out  DATA_SIZE  read word, valid while pop_valid=1
//   pop_valid     out  1          pop_data valid; one cycle after the accepted pop
//   full          out  1          occupancy == DEPTH
//   empty         out  1          occupancy == 0
//   almost_full   out  1          occupancy >= AF_THR
//   almost_empty  out  1          occupancy <= AE_THR
//   occupancy     out  MAIN_SIZE  stored entries, 0..DEPTH
//   overflow_err  out  1          sticky: push while full
//   underflow_err out  1          sticky: pop while empty
//   mem_write     out  1          to memory6x8 write
//   mem_read      out  1          to memory6x8 read
//   mem_wr_ptr    out  MAIN_SIZE  to memory6x8 wr_ptr
//   mem_rd_ptr    out  MAIN_SIZE  to memory6x8 rd_ptr
//   mem_data_in   out  DATA_SIZE  to memory6x8 data_in
//   mem_data_out  in   DATA_SIZE  from memory6x8 data_out; registered one cycle after read
// BEHAVIOUR
//   Reset (reset=0, async): wr_ptr=rd_ptr=0, occupancy=0, empty=1, almost_empty=1, all other
//     outputs 0. mem_write/mem_read are forced 0 while reset=0. An in-flight pop_valid drops.
//   push_acc = push & ~full. pop_acc = pop & ~empty. Flags use registered state at cycle start.
//   Rejected push: no memory write, no pointer change, overflow_err <= 1.
//   Rejected pop: no memory read, no pointer change, underflow_err <= 1.
//   Errors stay set until reset.
//   mem_write = push_acc, mem_wr_ptr = wr_ptr, mem_data_in = push_data (combinational).
//     The write lands at the same edge; wr_ptr then advances.
//   mem_read = pop_acc, mem_rd_ptr = rd_ptr (combinational). rd_ptr advances at the edge.
//     pop_valid <= pop_acc. pop_data = mem_data_out while pop_valid=1, else 0.
//   Pointer advance: ptr <= (ptr == DEPTH-1) ? 0 : ptr+1.
//   Occupancy: +1 on push_acc only, -1 on pop_acc only, unchanged if both or neither.
//   Flags are registered from the next occupancy, so they update at the same edge.
//   Simultaneous push & pop:
//     - full: pop accepted, push rejected (overflow_err=1); avoids the same-address hazard.
//     - empty: push accepted, pop rejected (underflow_err=1); no write-through bypass.
//     - otherwise: both accepted, occupancy unchanged.
//   Back-to-back pops at full rate: one word per cycle, fixed 1-cycle latency.
// CONFIGURATION
//   THRESH_PROG_EN defined: adds inputs thr_af and thr_ae [MAIN_SIZE-1:0]. These replace
//     AF_THR/AE_THR in the almost flag compares, sampled every cycle. Values are the
//     client's responsibility.
//   THRESH_PROG_EN undefined: the ports are absent and the fixed parameters are used.
// STRUCTURE
//   Shared include fifo_defs.vh: MAIN_SIZE/DATA_SIZE defaults, DEPTH, default AF_THR/AE_THR.
//   Sub-module fifo_ptr_6x8: mod-DEPTH wrapping pointer register (clk, reset, inc, ptr).
//     Instantiated twice, once for wr and once for rd.
//   Occupancy counter, flag registers and error bits live in the top.
// TESTING
//   1. Reset low mid-run, then high -> occupancy=0, empty=1, almost_empty=1, full=0,
//      mem_write=0, errors=0.
//   2. Push 0xA1..0xA6 on consecutive cycles -> mem_wr_ptr 0..5, almost_full rises after
//      the 4th, full after the 6th. 7th push 0xA7 -> mem_write=0, overflow_err=1.
//   3. Pop 6 times from full -> pop_data A1..A6, each 1 cycle after its pop.
//      rd_ptr wraps 5->0, empty=1, almost_empty after 5th.
//   4. At occupancy 3, push 0x55 and pop together for 4 cycles -> occupancy stays 3.
//      Both pointers advance with wrap; data order preserved.
//   5. Empty, then push 0x3C and pop together -> only the push is accepted: occupancy=1,
//      pop_valid stays 0, underflow_err=1.
//   6. THRESH_PROG_EN build, thr_af=2, thr_ae=0 -> almost_full at occupancy 2,
//      almost_empty only at 0.

Source files
------------

// File: rtl/fifo_ctrl_6x8_pkg.sv
// fifo_ctrl_6x8_pkg: default sizes and thresholds shared by the FIFO controller files
package fifo_ctrl_6x8_pkg;
    localparam int DEF_MAIN_SIZE = 6;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_DEPTH     = 6;
    localparam int DEF_AF_THR    = 4;
    localparam int DEF_AE_THR    = 1;
endpackage

// File: rtl/fifo_ptr_6x8.sv
// fifo_ptr_6x8: mod-DEPTH wrapping pointer register (clk, reset active-low async, inc, ptr)
module fifo_ptr_6x8
    import fifo_ctrl_6x8_pkg::*;
#(
    parameter int W     = DEF_MAIN_SIZE,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl_6x8.sv
// fifo_ctrl_6x8: push/pop FIFO controller driving a memory6x8 instance
// Ports: clk, reset (async active-low), push/push_data, pop -> pop_data/pop_valid,
//   full/empty/almost_full/almost_empty/occupancy, sticky overflow_err/underflow_err,
//   memory side mem_write/mem_read/mem_wr_ptr/mem_rd_ptr/mem_data_in, mem_data_out.
// THRESH_PROG_EN adds thr_af/thr_ae inputs replacing AF_THR/AE_THR.
module fifo_ctrl_6x8
    import fifo_ctrl_6x8_pkg::*;
#(
    parameter int MAIN_SIZE = DEF_MAIN_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THR    = DEF_AF_THR,
    parameter int AE_THR    = DEF_AE_THR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
`ifdef THRESH_PROG_EN
    input  logic [MAIN_SIZE-1:0] thr_af,
    input  logic [MAIN_SIZE-1:0] thr_ae,
`endif
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [MAIN_SIZE-1:0] occupancy,
    output logic                 overflow_err,
    output logic                 underflow_err,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [MAIN_SIZE-1:0] mem_wr_ptr,
    output logic [MAIN_SIZE-1:0] mem_rd_ptr,
    output logic [DATA_SIZE-1:0] mem_data_in,
    input  logic [DATA_SIZE-1:0] mem_data_out
);
    localparam logic [MAIN_SIZE-1:0] DEPTH_W = MAIN_SIZE'(DEPTH);
    logic                 push_acc, pop_acc;
    logic [MAIN_SIZE-1:0] occ_nxt, af_lvl, ae_lvl;
`ifdef THRESH_PROG_EN
    assign af_lvl = thr_af;
    assign ae_lvl = thr_ae;
`else
    assign af_lvl = MAIN_SIZE'(AF_THR);
    assign ae_lvl = MAIN_SIZE'(AE_THR);
`endif
    // full blocks push and empty blocks pop, so a simultaneous push/pop never hits one address
    assign push_acc    = push & ~full;
    assign pop_acc     = pop & ~empty;
    assign occ_nxt     = occupancy + MAIN_SIZE'(push_acc) - MAIN_SIZE'(pop_acc);
    // memory strobes are held off while reset is asserted, independent of the clock
    assign mem_write   = reset & push_acc;
    assign mem_read    = reset & pop_acc;
    assign mem_data_in = push_data;
    assign pop_data    = pop_valid ? mem_data_out : '0;
    fifo_ptr_6x8 #(.W(MAIN_SIZE), .DEPTH(DEPTH)) u_wr_ptr (
        .clk(clk), .reset(reset), .inc(push_acc), .ptr(mem_wr_ptr)
    );
    fifo_ptr_6x8 #(.W(MAIN_SIZE), .DEPTH(DEPTH)) u_rd_ptr (
        .clk(clk), .reset(reset), .inc(pop_acc), .ptr(mem_rd_ptr)
    );
    // flags are registered from the next occupancy so they track it on the same edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            occupancy     <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            pop_valid     <= 1'b0;
        end else begin
            occupancy     <= occ_nxt;
            full          <= occ_nxt == DEPTH_W;
            empty         <= occ_nxt == '0;
            almost_full   <= occ_nxt >= af_lvl;
            almost_empty  <= occ_nxt <= ae_lvl;
            overflow_err  <= overflow_err | (push & full);
            underflow_err <= underflow_err | (pop & empty);
            pop_valid     <= pop_acc;
        end
endmodule
